// File: rtl/input_conditioner.sv
// Button/switch front end: per-channel 2-flop synchronizer and counter debounce,
// rising-edge pulses for stc/run, and an auto-repeating pulse generator for inc.
module input_conditioner #(
  parameter int DB_CYCLES  = 16,
  parameter int REP_DELAY  = 64,
  parameter int REP_PERIOD = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stc_raw,
  input  logic inc_raw,
  input  logic run_raw,
  input  logic sw_raw,
  output logic stc,
  output logic inc,
  output logic run,
  output logic sw
);

  localparam int DW   = $clog2(DB_CYCLES);
  localparam int RMAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int RW   = $clog2(RMAX);
  localparam logic [DW-1:0] DB_LAST     = DW'(DB_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REP_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REP_PERIOD - 1);

  // Channel order in all 4-bit vectors: [0]=stc, [1]=inc, [2]=run, [3]=sw.
  logic [3:0]    raw_s;
  logic [3:0]    sync1_r;
  logic [3:0]    sync2_r;
  logic [3:0]    stable_r;
  logic [2:0]    prev_r;
  logic [DW-1:0] db_cnt_r [4];

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [RW-1:0] rep_cnt_r;
  logic [RW-1:0] rep_cnt_s;
  logic          inc_s;
  logic          inc_rise_s;

  assign raw_s = {sw_raw, run_raw, inc_raw, stc_raw};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r <= 4'b0000;
      sync2_r <= 4'b0000;
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
    end
  end

  // The counter tops out at DB_LAST and then flips stable, so it never wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stable_r <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        db_cnt_r[i] <= {DW{1'b0}};
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2_r[i] == stable_r[i]) begin
          db_cnt_r[i] <= {DW{1'b0}};
        end else if (db_cnt_r[i] == DB_LAST) begin
          stable_r[i] <= ~stable_r[i];
          db_cnt_r[i] <= {DW{1'b0}};
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_r <= 3'b000;
      stc    <= 1'b0;
      run    <= 1'b0;
    end else begin
      prev_r <= stable_r[2:0];
      stc    <= stable_r[0] & ~prev_r[0];
      run    <= stable_r[2] & ~prev_r[2];
    end
  end

  assign sw         = stable_r[3];
  assign inc_rise_s = stable_r[1] & ~prev_r[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      rep_cnt_r <= {RW{1'b0}};
      inc       <= 1'b0;
    end else begin
      state_r   <= state_s;
      rep_cnt_r <= rep_cnt_s;
      inc       <= inc_s;
    end
  end

  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (inc_rise_s) state_s = HOLD;
        else            state_s = IDLE;
      end
      HOLD: begin
        if (!stable_r[1])                 state_s = IDLE;
        else if (rep_cnt_r == DELAY_LAST) state_s = REPEAT;
        else                              state_s = HOLD;
      end
      REPEAT: begin
        if (!stable_r[1]) state_s = IDLE;
        else              state_s = REPEAT;
      end
      default: state_s = IDLE;
    endcase
  end

  // Release is checked before the terminal count so a coincident pulse is dropped.
  always_comb begin
    inc_s     = 1'b0;
    rep_cnt_s = rep_cnt_r;
    case (state_r)
      IDLE: begin
        rep_cnt_s = {RW{1'b0}};
        inc_s     = inc_rise_s;
      end
      HOLD: begin
        if (!stable_r[1]) begin
          rep_cnt_s = {RW{1'b0}};
        end else if (rep_cnt_r == DELAY_LAST) begin
          inc_s     = 1'b1;
          rep_cnt_s = {RW{1'b0}};
        end else begin
          rep_cnt_s = rep_cnt_r + RW'(1);
        end
      end
      REPEAT: begin
        if (!stable_r[1]) begin
          rep_cnt_s = {RW{1'b0}};
        end else if (rep_cnt_r == PERIOD_LAST) begin
          inc_s     = 1'b1;
          rep_cnt_s = {RW{1'b0}};
        end else begin
          rep_cnt_s = rep_cnt_r + RW'(1);
        end
      end
      default: begin
        inc_s     = 1'b0;
        rep_cnt_s = {RW{1'b0}};
      end
    endcase
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner (DB_CYCLES=4, REP_DELAY=8, REP_PERIOD=3);
// outputs are recorded per edge (edge 1 = first edge after the stimulus change).
module tb_input_conditioner;

  logic clk;
  logic rst_n;
  logic stc_raw;
  logic inc_raw;
  logic run_raw;
  logic sw_raw;
  logic stc;
  logic inc;
  logic run;
  logic sw;

  int n_cmp;
  int n_err;
  int edge_k;
  logic [127:0] stc_h;
  logic [127:0] inc_h;
  logic [127:0] run_h;
  logic [127:0] sw_h;
  logic [127:0] exp_inc;

  input_conditioner #(
    .DB_CYCLES (4),
    .REP_DELAY (8),
    .REP_PERIOD(3)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .stc_raw(stc_raw),
    .inc_raw(inc_raw),
    .run_raw(run_raw),
    .sw_raw (sw_raw),
    .stc    (stc),
    .inc    (inc),
    .run    (run),
    .sw     (sw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_hist();
    stc_h  = 128'd0;
    inc_h  = 128'd0;
    run_h  = 128'd0;
    sw_h   = 128'd0;
    edge_k = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_k++;
    stc_h[edge_k] = stc;
    inc_h[edge_k] = inc;
    run_h[edge_k] = run;
    sw_h[edge_k]  = sw;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic int ones(input logic [127:0] v, input int lo, input int hi);
    int c;
    c = 0;
    for (int i = lo; i <= hi; i++) c += int'(v[i]);
    return c;
  endfunction

  task automatic do_reset();
    rst_n   = 1'b0;
    stc_raw = 1'b0;
    inc_raw = 1'b0;
    run_raw = 1'b0;
    sw_raw  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    stc_raw = 1'b1;
    inc_raw = 1'b1;
    run_raw = 1'b1;
    sw_raw  = 1'b1;
    clear_hist();

    // Reset with every raw input high: outputs must stay cleared.
    steps(6);
    check_eq("reset_outputs", 128'({stc, inc, run, sw}), 128'd0);
    check_eq("reset_no_activity", 128'(ones(stc_h | inc_h | run_h | sw_h, 1, 6)), 128'd0);
    stc_raw = 1'b0; inc_raw = 1'b0; run_raw = 1'b0; sw_raw = 1'b0;
    rst_n   = 1'b1;
    clear_hist();
    steps(10);
    check_eq("idle_after_reset", 128'(ones(stc_h | inc_h | run_h | sw_h, 1, 10)), 128'd0);

    // Clean stc press held 20 cycles, then release.
    do_reset();
    clear_hist();
    stc_raw = 1'b1;
    steps(20);
    check_eq("stc_edge6_low", 128'(stc_h[6]), 128'd0);
    check_eq("stc_edge7_high", 128'(stc_h[7]), 128'd1);
    check_eq("stc_edge8_low", 128'(stc_h[8]), 128'd0);
    check_eq("stc_press_count", 128'(ones(stc_h, 1, 20)), 128'd1);
    check_eq("stc_others_quiet", 128'(ones(inc_h | run_h | sw_h, 1, 20)), 128'd0);
    stc_raw = 1'b0;
    clear_hist();
    steps(15);
    check_eq("stc_release_count", 128'(ones(stc_h, 1, 15)), 128'd0);

    // run bounce 1-0-1-0-1 then held 10 cycles; stable rises at edge 10.
    do_reset();
    clear_hist();
    run_raw = 1'b1; step();
    run_raw = 1'b0; step();
    run_raw = 1'b1; step();
    run_raw = 1'b0; step();
    run_raw = 1'b1; step();
    steps(10);
    run_raw = 1'b0;
    steps(20);
    check_eq("run_bounce_quiet", 128'(ones(run_h, 1, 10)), 128'd0);
    check_eq("run_edge11_high", 128'(run_h[11]), 128'd1);
    check_eq("run_total_count", 128'(ones(run_h, 1, 35)), 128'd1);

    // inc held 40 cycles: pulses at 7, 15, then every 3 up to 45.
    do_reset();
    clear_hist();
    inc_raw = 1'b1;
    steps(40);
    inc_raw = 1'b0;
    steps(20);
    exp_inc = 128'd0;
    exp_inc[7]  = 1'b1;
    exp_inc[15] = 1'b1;
    for (int e = 18; e <= 45; e += 3) exp_inc[e] = 1'b1;
    check_eq("inc_pulse_pattern", inc_h, exp_inc);
    check_eq("inc_total_count", 128'(ones(inc_h, 1, 60)), 128'd12);
    check_eq("inc_after_release", 128'(ones(inc_h, 46, 60)), 128'd0);
    check_eq("inc_others_quiet", 128'(ones(stc_h | run_h, 1, 60)), 128'd0);

    // sw: 3-cycle glitch ignored, then a held level appears after 6 edges.
    do_reset();
    clear_hist();
    sw_raw = 1'b1;
    steps(3);
    sw_raw = 1'b0;
    steps(12);
    check_eq("sw_glitch_ignored", 128'(ones(sw_h, 1, 15)), 128'd0);
    clear_hist();
    sw_raw = 1'b1;
    steps(10);
    check_eq("sw_edge5_low", 128'(sw_h[5]), 128'd0);
    check_eq("sw_edge6_high", 128'(sw_h[6]), 128'd1);
    check_eq("sw_stays_high", 128'(ones(sw_h, 6, 10)), 128'd5);
    check_eq("sw_no_pulses", 128'(ones(stc_h | inc_h | run_h, 1, 10)), 128'd0);

    // Reset during inc REPEAT, inc held through reset release.
    do_reset();
    clear_hist();
    inc_raw = 1'b1;
    steps(20);
    check_eq("inc_pre_reset_18", 128'(inc_h[18]), 128'd1);
    rst_n = 1'b0;
    clear_hist();
    steps(2);
    check_eq("inc_in_reset", 128'(ones(inc_h, 1, 2)), 128'd0);
    rst_n = 1'b1;
    clear_hist();
    steps(20);
    check_eq("inc_post_reset_6", 128'(inc_h[6]), 128'd0);
    check_eq("inc_post_reset_7", 128'(inc_h[7]), 128'd1);
    check_eq("inc_post_reset_hold", 128'(ones(inc_h, 8, 14)), 128'd0);
    check_eq("inc_post_reset_15", 128'(inc_h[15]), 128'd1);
    check_eq("inc_post_reset_18", 128'(inc_h[18]), 128'd1);

    // Simultaneous stc+inc press; stc held long must give one pulse.
    do_reset();
    clear_hist();
    stc_raw = 1'b1;
    inc_raw = 1'b1;
    steps(100);
    check_eq("stc_inc_same_edge", 128'({stc_h[7], inc_h[7]}), 128'd3);
    check_eq("stc_long_hold_count", 128'(ones(stc_h, 1, 100)), 128'd1);
    check_eq("run_quiet_dual", 128'(ones(run_h, 1, 100)), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
